array_accum: RTL and testbench

ARRAY_ACCUM -- requirements
Module: array_accum

---
 rtl/cella_pkg.sv | 16 +
 rtl/adder_tree16.sv | 28 ++
 rtl/array_accum.sv | 139 +++++++++++++
 tb/tb_array_accum.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cella_pkg.sv
// Shared defaults and FSM encoding for the bit-plane array accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cella_pkg;

    localparam int ADD_W_DEF     = 8;
    localparam int MAX_BEATS_DEF = 8;
    localparam int ACC_W_DEF     = ADD_W_DEF + 4 + MAX_BEATS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_tree16.sv
// Unsigned sum of sixteen per-bank partial products, four-level balanced tree.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
module adder_tree16 #(
    parameter int ADD_W = 8
) (
    input  logic [15:0][ADD_W-1:0] add,
    output logic [ADD_W+3:0]       sum
);

    logic [ADD_W:0]   lvl1 [8];
    logic [ADD_W+1:0] lvl2 [4];
    logic [ADD_W+2:0] lvl3 [2];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl1[i] = {1'b0, add[2*i]} + {1'b0, add[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        end
        sum = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};
    end

endmodule

// File: rtl/array_accum.sv
// Bit-plane MAC / search-hit accumulator over 16 banks; ARRAY_ACCUM_SIGNED_EN makes plane 0 a sign plane.
// Latency: result valid the cycle after the last (or MAX_BEATS-th) beat is accepted.
// Backpressure: in_ready drops while a result is held; released by the out_valid/out_ready handshake.
module array_accum
    import cella_pkg::*;
#(
    parameter  int ADD_W     = ADD_W_DEF,
    parameter  int MAX_BEATS = MAX_BEATS_DEF,
    localparam int ACC_W     = ADD_W + 4 + MAX_BEATS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             mac_en,
    input  logic [ADD_W-1:0] add0,
    input  logic [ADD_W-1:0] add1,
    input  logic [ADD_W-1:0] add2,
    input  logic [ADD_W-1:0] add3,
    input  logic [ADD_W-1:0] add4,
    input  logic [ADD_W-1:0] add5,
    input  logic [ADD_W-1:0] add6,
    input  logic [ADD_W-1:0] add7,
    input  logic [ADD_W-1:0] add8,
    input  logic [ADD_W-1:0] add9,
    input  logic [ADD_W-1:0] add10,
    input  logic [ADD_W-1:0] add11,
    input  logic [ADD_W-1:0] add12,
    input  logic [ADD_W-1:0] add13,
    input  logic [ADD_W-1:0] add14,
    input  logic [ADD_W-1:0] add15,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [ACC_W-1:0] acc_out,
    output logic [15:0]      match_vec,
    output logic [4:0]       match_cnt,
    output logic [3:0]       match_idx,
    output logic             match_any,
    output logic             ovf
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        beat_cnt, beat_cnt_nxt;
    logic [15:0][ADD_W-1:0]  add_bus;
    logic [ADD_W+3:0]        sum;
    logic [ACC_W-1:0]        sum_ext, first_acc, acc_nxt;
    logic [15:0]             hit, vec_nxt;
    logic [4:0]              cnt_nxt;
    logic [3:0]              idx_nxt;
    logic                    accept, close;

    assign add_bus = {add15, add14, add13, add12, add11, add10, add9, add8,
                      add7,  add6,  add5,  add4,  add3,  add2,  add1, add0};

    adder_tree16 #(.ADD_W(ADD_W)) u_tree (
        .add (add_bus),
        .sum (sum)
    );

    assign accept       = in_valid && in_ready;
    assign beat_cnt_nxt = (state == ST_IDLE) ? CNT_W'(1) : beat_cnt + CNT_W'(1);
    assign close        = in_last || (beat_cnt_nxt == CNT_W'(MAX_BEATS));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = close ? ST_HOLD : ST_ACCUM;
            ST_ACCUM: if (accept && close) state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != ST_HOLD);
        out_valid = (state == ST_HOLD);
    end

    always_comb begin
        sum_ext = ACC_W'(sum);
`ifdef ARRAY_ACCUM_SIGNED_EN
        first_acc = '0 - sum_ext;
`else
        first_acc = sum_ext;
`endif
        for (int i = 0; i < 16; i++) hit[i] = add_bus[i][0];
        acc_nxt = acc_out;
        vec_nxt = match_vec;
        // mode comes straight from mac_en on the opening beat, from the latch afterwards
        if (state == ST_IDLE) begin
            acc_nxt = mac_en ? first_acc : '0;
            vec_nxt = mac_en ? 16'h0 : hit;
        end else if (out_mode) begin
            acc_nxt = {acc_out[ACC_W-2:0], 1'b0} + sum_ext;
        end else begin
            vec_nxt = match_vec | hit;
        end
        cnt_nxt = '0;
        idx_nxt = '0;
        for (int i = 15; i >= 0; i--) begin
            cnt_nxt = cnt_nxt + 5'(vec_nxt[i]);
            if (vec_nxt[i]) idx_nxt = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            out_mode  <= 1'b0;
            acc_out   <= '0;
            match_vec <= '0;
            match_cnt <= '0;
            match_idx <= '0;
            match_any <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            beat_cnt  <= beat_cnt_nxt;
            acc_out   <= acc_nxt;
            match_vec <= vec_nxt;
            ovf       <= close && !in_last;
            if (state == ST_IDLE) out_mode <= mac_en;
            if (close) begin
                match_cnt <= cnt_nxt;
                match_idx <= idx_nxt;
                match_any <= |vec_nxt;
            end
        end
    end

endmodule

// File: tb/tb_array_accum.sv
// Directed bench for array_accum at default parameters; signed case runs when ARRAY_ACCUM_SIGNED_EN is defined.
module tb_array_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, mac_en;
    logic [7:0]  add [16];
    logic        out_valid, out_ready, out_mode;
    logic [19:0] acc_out;
    logic [15:0] match_vec;
    logic [4:0]  match_cnt;
    logic [3:0]  match_idx;
    logic        match_any, ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    array_accum dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .mac_en(mac_en),
        .add0(add[0]),   .add1(add[1]),   .add2(add[2]),   .add3(add[3]),
        .add4(add[4]),   .add5(add[5]),   .add6(add[6]),   .add7(add[7]),
        .add8(add[8]),   .add9(add[9]),   .add10(add[10]), .add11(add[11]),
        .add12(add[12]), .add13(add[13]), .add14(add[14]), .add15(add[15]),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .acc_out(acc_out), .match_vec(match_vec), .match_cnt(match_cnt),
        .match_idx(match_idx), .match_any(match_any), .ovf(ovf)
    );

    // Present one beat at the falling edge, let the rising edge take it, sample #1 later.
    task automatic beat(input logic [15:0][7:0] v, input logic last, input logic mode);
        @(negedge clk);
        for (int i = 0; i < 16; i++) add[i] = v[i];
        in_valid = 1'b1;
        in_last  = last;
        mac_en   = mode;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (acc_out !== 20'd0)   begin n_bad++; $display("FAIL rst_acc got %h want 0", acc_out); end
        n_cmp++; if (match_vec !== 16'd0) begin n_bad++; $display("FAIL rst_vec got %h want 0", match_vec); end
        n_cmp++; if ({match_cnt, match_idx, match_any} !== 10'd0)
                     begin n_bad++; $display("FAIL rst_match got %0d/%0d/%b want 0/0/0", match_cnt, match_idx, match_any); end
        n_cmp++; if ({ovf, out_mode} !== 2'b00) begin n_bad++; $display("FAIL rst_flags got %b%b want 00", ovf, out_mode); end
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_mac();
        logic [15:0][7:0] v;
        v = '0; v[0] = 8'd10; v[15] = 8'd6;          // sum 16
        beat(v, 1'b0, 1'b1);
        v = '0;                                      // sum 0
        beat(v, 1'b0, 1'b0);                         // mac_en flip mid-frame is ignored
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mac_early_valid got %b want 0", out_valid); end
        v = '0; v[3] = 8'd2; v[12] = 8'd3;           // sum 5
        beat(v, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mac_valid got %b want 1", out_valid); end
        n_cmp++; if (acc_out !== 20'd69) begin n_bad++; $display("FAIL mac_acc got %0d want 69", acc_out); end
        n_cmp++; if (out_mode !== 1'b1)  begin n_bad++; $display("FAIL mac_mode got %b want 1", out_mode); end
        n_cmp++; if (ovf !== 1'b0)       begin n_bad++; $display("FAIL mac_ovf got %b want 0", ovf); end
        n_cmp++; if ({match_vec, match_cnt} !== 21'd0) begin n_bad++; $display("FAIL mac_match got %h/%0d want 0/0", match_vec, match_cnt); end
        n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL mac_in_ready got %b want 0", in_ready); end
        handshake();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mac_release got %b want 0", out_valid); end
    endtask

    task automatic test_search();
        logic [15:0][7:0] v;
        v = '0; v[3] = 8'h01; v[9] = 8'h03; v[4] = 8'hFE;   // add4 has only ignored bits
        beat(v, 1'b1, 1'b0);
        n_cmp++; if (match_vec !== 16'h0208) begin n_bad++; $display("FAIL srch_vec got %h want 0208", match_vec); end
        n_cmp++; if (match_cnt !== 5'd2)     begin n_bad++; $display("FAIL srch_cnt got %0d want 2", match_cnt); end
        n_cmp++; if (match_idx !== 4'd3)     begin n_bad++; $display("FAIL srch_idx got %0d want 3", match_idx); end
        n_cmp++; if (match_any !== 1'b1)     begin n_bad++; $display("FAIL srch_any got %b want 1", match_any); end
        n_cmp++; if ({acc_out, out_mode} !== 21'd0) begin n_bad++; $display("FAIL srch_acc got %h/%b want 0/0", acc_out, out_mode); end
        handshake();
        v = '0; v[15] = 8'h01;
        beat(v, 1'b0, 1'b0);
        v = '0; v[1] = 8'h01;
        beat(v, 1'b1, 1'b1);
        n_cmp++; if (match_vec !== 16'h8002) begin n_bad++; $display("FAIL srch2_vec got %h want 8002", match_vec); end
        n_cmp++; if ({match_cnt, match_idx, match_any, out_mode} !== {5'd2, 4'd1, 1'b1, 1'b0})
                     begin n_bad++; $display("FAIL srch2_stats got %0d/%0d/%b/%b want 2/1/1/0", match_cnt, match_idx, match_any, out_mode); end
        handshake();
    endtask

    task automatic test_hold();
        logic [15:0][7:0] v;
        v = '0; v[8] = 8'd7;
        beat(v, 1'b1, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 16; i++) add[i] = 8'd0;
        add[0] = 8'd3; in_valid = 1'b1; in_last = 1'b1; mac_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_bad++; $display("FAIL hold_hs%0d got %b%b want 10", c, out_valid, in_ready); end
            n_cmp++; if (acc_out !== 20'd7) begin n_bad++; $display("FAIL hold_acc%0d got %0d want 7", c, acc_out); end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL hold_release got %b%b want 01", out_valid, in_ready); end
        @(negedge clk); out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++; if ({out_valid, acc_out} !== {1'b1, 20'd3}) begin n_bad++; $display("FAIL hold_next got %b/%0d want 1/3", out_valid, acc_out); end
        handshake();
    endtask

    task automatic test_ovf();
        logic [15:0][7:0] v;
        v = '0; v[5] = 8'd1;
        for (int b = 1; b <= 8; b++) begin
            beat(v, 1'b0, 1'b1);
            if (b == 7) begin
                n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_early got %b want 0", out_valid); end
            end
        end
        n_cmp++; if ({out_valid, ovf} !== 2'b11) begin n_bad++; $display("FAIL ovf_close got %b%b want 11", out_valid, ovf); end
        n_cmp++; if (acc_out !== 20'd255) begin n_bad++; $display("FAIL ovf_acc got %0d want 255", acc_out); end
        handshake();
        beat(v, 1'b1, 1'b1);
        n_cmp++; if ({out_valid, ovf, acc_out} !== {2'b10, 20'd1}) begin n_bad++; $display("FAIL ovf_beat9 got %b%b/%0d want 10/1", out_valid, ovf, acc_out); end
        handshake();
    endtask

    task automatic test_reset_mid();
        logic [15:0][7:0] v;
        v = '0; v[2] = 8'd9;
        beat(v, 1'b0, 1'b1);
        beat(v, 1'b0, 1'b1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL rmid_c%0d got %b%b want 01", c, out_valid, in_ready); end
        end
        n_cmp++; if (acc_out !== 20'd0) begin n_bad++; $display("FAIL rmid_acc got %0d want 0", acc_out); end
        v = '0; v[0] = 8'd4; v[10] = 8'd3;
        beat(v, 1'b1, 1'b1);
        n_cmp++; if ({out_valid, acc_out} !== {1'b1, 20'd7}) begin n_bad++; $display("FAIL rmid_fresh got %b/%0d want 1/7", out_valid, acc_out); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        n_cmp++; if ({out_valid, out_mode, acc_out} !== 22'd0) begin n_bad++; $display("FAIL rhold got %b%b/%0d want 00/0", out_valid, out_mode, acc_out); end
    endtask

`ifdef ARRAY_ACCUM_SIGNED_EN
    task automatic test_signed();
        logic [15:0][7:0] v;
        v = '0; v[6] = 8'd1;
        beat(v, 1'b0, 1'b1);
        v = '0;
        beat(v, 1'b1, 1'b1);
        n_cmp++; if (acc_out !== 20'hFFFFE) begin n_bad++; $display("FAIL signed_acc got %h want FFFFE", acc_out); end
        handshake();
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; mac_en = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) add[i] = 8'd0;
        test_reset();
`ifdef ARRAY_ACCUM_SIGNED_EN
        test_signed();
`else
        test_mac();
        test_ovf();
`endif
        test_search();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
